// File: rtl/pool_stream_kxk_if.sv
// Stream bundle for pool_stream_kxk: input pixel beats, pooled output beats and frame status.
interface pool_stream_kxk_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 4
);
    logic                      max_avg;
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*DATA_W-1:0]   out_data;
    logic                      out_last;
    logic                      frame_done;

    modport slave (
        input  max_avg, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, frame_done
    );

    modport master (
        output max_avg, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, frame_done
    );
endinterface

// File: rtl/pool_stream_kxk.sv
// Streaming KxK max/average pooling over raster-order frames, LANES channels per beat.
// K-1 line buffers plus a KxK window; one output register with valid/ready backpressure.
module pool_stream_kxk #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned W      = 32,
    parameter int unsigned H      = 32,
    parameter int unsigned K      = 2,
    parameter int unsigned S      = 2
) (
    input  logic               clk,
    input  logic               rst,
    pool_stream_kxk_if.slave   bus
);
    localparam int unsigned W_P      = (W - K) / S + 1;
    localparam int unsigned H_P      = (H - K) / S + 1;
    localparam int unsigned PIX_W    = LANES * DATA_W;
    localparam int unsigned COL_W    = $clog2(W);
    localparam int unsigned ROW_W    = $clog2(H);
    localparam int unsigned KK       = K * K;
    localparam int unsigned SUM_W    = DATA_W + $clog2(KK);
    localparam int unsigned LAST_COL = K - 1 + (W_P - 1) * S;
    localparam int unsigned LAST_ROW = K - 1 + (H_P - 1) * S;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               mode_q, mode_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               frame_done_q, frame_done_d;
    logic [PIX_W-1:0]   out_data_q, out_data_d;

    logic [PIX_W-1:0]   lb_q  [K-1][W];
    logic [PIX_W-1:0]   win_q [K][K-1];
    logic [PIX_W-1:0]   win_c [K][K];
    logic [PIX_W-1:0]   pool_c;

    logic in_ready_c, accept_c, out_hs_c, last_beat_c, emit_c, emit_last_c, mode_c;

    // Handshake and window-position decode for the beat currently offered.
    always_comb begin
        in_ready_c  = !rst && (state_q != DRAIN) && (!out_valid_q || bus.out_ready);
        accept_c    = bus.in_valid && in_ready_c;
        out_hs_c    = out_valid_q && bus.out_ready;
        last_beat_c = (32'(col_q) == W - 1) && (32'(row_q) == H - 1);
        mode_c      = (state_q == IDLE) ? bus.max_avg : mode_q;
        emit_c      = accept_c
                   && (32'(col_q) >= K - 1) && (32'(row_q) >= K - 1)
                   && ((32'(col_q) - (K - 1)) % S == 0)
                   && ((32'(row_q) - (K - 1)) % S == 0);
        emit_last_c = (32'(col_q) == LAST_COL) && (32'(row_q) == LAST_ROW);
    end

    // Full window: K-1 stored columns plus the new column (buffered rows on top, live pixel last).
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) win_c[r][c] = '0;
            for (int c = 0; c < K - 1; c++) win_c[r][c] = win_q[r][c];
        end
        for (int r = 0; r < K - 1; r++) win_c[r][K-1] = lb_q[r][col_q];
        win_c[K-1][K-1] = bus.in_data;
    end

    always_comb begin : p_pool
        logic [DATA_W-1:0] px;
        logic [DATA_W-1:0] mx;
        logic [SUM_W-1:0]  sum;
        logic [SUM_W-1:0]  avg;
        pool_c = '0;
        px     = '0;
        mx     = '0;
        sum    = '0;
        avg    = '0;
        for (int l = 0; l < LANES; l++) begin
            mx  = '0;
            sum = '0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    px  = win_c[r][c][l*DATA_W +: DATA_W];
                    mx  = (px > mx) ? px : mx;
                    sum = sum + SUM_W'(px);
                end
            end
            // Round half up; the quotient never exceeds the largest pixel value.
            avg = (sum + SUM_W'(KK / 2)) / SUM_W'(KK);
            pool_c[l*DATA_W +: DATA_W] = mode_c ? mx : DATA_W'(avg);
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        mode_d       = mode_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        frame_done_d = out_hs_c && out_last_q;

        if (accept_c) begin
            if (32'(col_q) == W - 1) begin
                col_d = '0;
                row_d = (32'(row_q) == H - 1) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        unique case (state_q)
            IDLE: if (accept_c) begin
                mode_d  = bus.max_avg;
                state_d = last_beat_c ? DRAIN : ACTIVE;
            end
            ACTIVE: if (accept_c && last_beat_c) state_d = DRAIN;
            DRAIN:  if (!out_valid_q || bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (emit_c) begin
            out_valid_d = 1'b1;
            out_data_d  = pool_c;
            out_last_d  = emit_last_c;
        end else if (out_hs_c) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            for (int j = 0; j < K - 1; j++)
                for (int i = 0; i < W; i++) lb_q[j][i] <= '0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K - 1; c++) win_q[r][c] <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            mode_q       <= mode_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            if (accept_c) begin
                // Each line buffer column shifts up one row; the live pixel enters the newest row.
                for (int j = 0; j < K - 2; j++) lb_q[j][col_q] <= lb_q[j+1][col_q];
                lb_q[K-2][col_q] <= bus.in_data;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K - 1; c++) win_q[r][c] <= win_c[r][c+1];
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_last   = out_last_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_pool_stream_kxk.sv
// Bench for pool_stream_kxk: three geometries behind one stimulus mux, table vectors,
// directed stall/reset sequences and random frames against a window-arithmetic model.
module tb_pool_stream_kxk;
    localparam int unsigned PW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    sel;
    logic          in_valid, max_avg, out_ready;
    logic [PW-1:0] in_data;

    pool_stream_kxk_if #(.DATA_W(8), .LANES(4)) if_a ();
    pool_stream_kxk_if #(.DATA_W(8), .LANES(4)) if_b ();
    pool_stream_kxk_if #(.DATA_W(8), .LANES(4)) if_c ();

    assign if_a.in_valid = in_valid && (sel == 2'd0);
    assign if_b.in_valid = in_valid && (sel == 2'd1);
    assign if_c.in_valid = in_valid && (sel == 2'd2);
    assign if_a.out_ready = out_ready && (sel == 2'd0);
    assign if_b.out_ready = out_ready && (sel == 2'd1);
    assign if_c.out_ready = out_ready && (sel == 2'd2);
    assign if_a.in_data = in_data;
    assign if_b.in_data = in_data;
    assign if_c.in_data = in_data;
    assign if_a.max_avg = max_avg;
    assign if_b.max_avg = max_avg;
    assign if_c.max_avg = max_avg;

    pool_stream_kxk #(.DATA_W(8), .LANES(4), .W(4), .H(4), .K(2), .S(2))
        u_a (.clk(clk), .rst(rst), .bus(if_a));
    pool_stream_kxk #(.DATA_W(8), .LANES(4), .W(5), .H(5), .K(3), .S(1))
        u_b (.clk(clk), .rst(rst), .bus(if_b));
    pool_stream_kxk #(.DATA_W(8), .LANES(4), .W(5), .H(5), .K(2), .S(2))
        u_c (.clk(clk), .rst(rst), .bus(if_c));

    logic          rdy_m, ov_m, ol_m, fd_m;
    logic [PW-1:0] od_m;
    always_comb begin
        rdy_m = if_a.in_ready; ov_m = if_a.out_valid; ol_m = if_a.out_last;
        fd_m = if_a.frame_done; od_m = if_a.out_data;
        if (sel == 2'd1) begin
            rdy_m = if_b.in_ready; ov_m = if_b.out_valid; ol_m = if_b.out_last;
            fd_m = if_b.frame_done; od_m = if_b.out_data;
        end else if (sel == 2'd2) begin
            rdy_m = if_c.in_ready; ov_m = if_c.out_valid; ol_m = if_c.out_last;
            fd_m = if_c.frame_done; od_m = if_c.out_data;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Geometry per mux slot (square maps).
    int gw [3] = '{4, 5, 5};
    int gk [3] = '{2, 3, 2};
    int gs [3] = '{2, 1, 2};

    typedef struct { logic [PW-1:0] d; bit last; } exp_t;
    exp_t          exp_q [$];
    logic [PW-1:0] px [64];
    int n_out = 0, n_last = 0, n_fd = 0;
    int stall_left = 0;
    int rprob = 100;

    // Reference: every KxK window at stride S, computed directly from the stored frame.
    task automatic push_model(input int s, input bit mode);
        int w, k, st, op, v, mx, sum;
        logic [PW-1:0] d;
        w = gw[s]; k = gk[s]; st = gs[s];
        op = (w - k) / st + 1;
        for (int orow = 0; orow < op; orow++) begin
            for (int ocol = 0; ocol < op; ocol++) begin
                d = '0;
                for (int l = 0; l < 4; l++) begin
                    mx = 0; sum = 0;
                    for (int r = 0; r < k; r++) begin
                        for (int c = 0; c < k; c++) begin
                            v = int'(px[(orow*st + r)*w + ocol*st + c][l*8 +: 8]);
                            if (v > mx) mx = v;
                            sum += v;
                        end
                    end
                    d[l*8 +: 8] = mode ? 8'(mx) : 8'((sum + (k*k)/2) / (k*k));
                end
                exp_q.push_back('{d, (orow == op-1) && (ocol == op-1)});
            end
        end
    endtask

    task automatic set_ready();
        if (stall_left > 0) begin
            out_ready = 1'b0;
            if (ov_m) stall_left--;
        end else begin
            out_ready = ($urandom_range(99) < rprob);
        end
    endtask

    task automatic send_frame(input int nbeats, input int vprob, input bit mode, input bit toggle);
        int idx = 0;
        int guard = 0;
        while (idx < nbeats) begin
            set_ready();
            in_valid = ($urandom_range(99) < vprob);
            in_data  = px[idx];
            max_avg  = (toggle && idx > 0) ? ~mode : mode;
            @(negedge clk);
            if (in_valid && rdy_m) idx++;
            @(posedge clk); #1;
            guard++;
            if (guard > 3000) begin
                chk(1'b0, "send_timeout", 32'(idx), 32'(nbeats));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !ov_m && stall_left == 0) break;
            set_ready();
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, nm, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic fill_random();
        for (int j = 0; j < 64; j++) px[j] = $urandom;
    endtask

    // Output-side monitor: scoreboard, hold-under-stall, frame_done timing.
    logic          p_stall = 1'b0, p_lhs = 1'b0;
    logic [PW-1:0] p_d = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            p_stall = 1'b0;
            p_lhs   = 1'b0;
        end else begin
            if (p_stall) begin
                chk(ov_m, "hold_valid", 32'(ov_m), 32'd1);
                chk(od_m == p_d, "hold_data", od_m, p_d);
            end
            if (ov_m && !out_ready) chk(!rdy_m, "stall_in_ready", 32'(rdy_m), 32'd0);
            chk(fd_m == p_lhs, "frame_done", 32'(fd_m), 32'(p_lhs));
            if (fd_m) n_fd++;
            if (ov_m && out_ready) begin
                n_out++;
                if (ol_m) n_last++;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_out", od_m, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(od_m == e.d, "out_data", od_m, e.d);
                    chk(ol_m == e.last, "out_last", 32'(ol_m), 32'(e.last));
                end
            end
            p_stall = ov_m && !out_ready;
            p_d     = od_m;
            p_lhs   = ov_m && out_ready && ol_m;
        end
    end

    typedef struct { int sel; int pat; bit mode; bit toggle; int n; int exp[9]; } vec_t;
    vec_t tbl [5];

    task automatic set_vec(input int i, input int s, input int pat, input bit mode, input bit tog, input int n);
        tbl[i].sel = s; tbl[i].pat = pat; tbl[i].mode = mode; tbl[i].toggle = tog; tbl[i].n = n;
    endtask

    initial begin
        int w, v, fd0, last0, out0;
        bit mode, tog;

        set_vec(0, 0, 0, 1'b1, 1'b0, 4); tbl[0].exp = '{5, 7, 13, 15, 0, 0, 0, 0, 0};
        set_vec(1, 0, 0, 1'b0, 1'b0, 4); tbl[1].exp = '{3, 5, 11, 13, 0, 0, 0, 0, 0};
        set_vec(2, 0, 0, 1'b0, 1'b1, 4); tbl[2].exp = '{3, 5, 11, 13, 0, 0, 0, 0, 0};
        set_vec(3, 1, 1, 1'b0, 1'b0, 9); tbl[3].exp = '{37, 37, 37, 37, 37, 37, 37, 37, 37};
        set_vec(4, 1, 1, 1'b1, 1'b1, 9); tbl[4].exp = '{255, 255, 255, 255, 255, 255, 255, 255, 255};

        sel = 2'd0; in_valid = 1'b1; out_ready = 1'b1; max_avg = 1'b0; in_data = '1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk(!rdy_m, "rst_in_ready", 32'(rdy_m), 32'd0);
            chk(!ov_m, "rst_out_valid", 32'(ov_m), 32'd0);
            chk(!ol_m, "rst_out_last", 32'(ol_m), 32'd0);
            chk(!fd_m, "rst_frame_done", 32'(fd_m), 32'd0);
            chk(od_m == '0, "rst_out_data", od_m, 32'd0);
        end
        in_valid = 1'b0;
        sel = 2'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            sel = 2'(tbl[i].sel);
            w = gw[tbl[i].sel];
            for (int j = 0; j < w*w; j++) begin
                v = (tbl[i].pat == 0) ? j : ((j == (w*w)/2) ? 255 : 10);
                px[j] = {4{8'(v)}};
            end
            for (int j = 0; j < tbl[i].n; j++)
                exp_q.push_back('{{4{8'(tbl[i].exp[j])}}, j == tbl[i].n - 1});
            fd0 = n_fd;
            send_frame(w*w, 100, tbl[i].mode, tbl[i].toggle);
            drain("table_drain");
            chk(n_fd - fd0 == 1, "table_frame_done_cnt", 32'(n_fd - fd0), 32'd1);
        end

        // First output held off for 10 cycles.
        sel = 2'd0;
        for (int j = 0; j < 16; j++) px[j] = {4{8'(j)}};
        push_model(0, 1'b1);
        stall_left = 10;
        send_frame(16, 100, 1'b1, 1'b0);
        drain("stall_drain");

        // Trailing column/row discard: 5x5, K=S=2.
        sel = 2'd2;
        fill_random();
        out0 = n_out;
        push_model(2, 1'b0);
        send_frame(25, 100, 1'b0, 1'b0);
        drain("w5_drain");
        chk(n_out - out0 == 4, "w5_count", 32'(n_out - out0), 32'd4);

        // Reset after 7 beats, then one clean frame.
        sel = 2'd1;
        fill_random();
        send_frame(7, 100, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fd0 = n_fd; last0 = n_last;
        fill_random();
        push_model(1, 1'b1);
        send_frame(25, 100, 1'b1, 1'b0);
        drain("rst_drain");
        chk(n_fd - fd0 == 1, "rst_frame_done_cnt", 32'(n_fd - fd0), 32'd1);
        chk(n_last - last0 == 1, "rst_last_cnt", 32'(n_last - last0), 32'd1);

        // Random back-to-back frames with random valid/ready.
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            fd0 = n_fd;
            for (int f = 0; f < 4; f++) begin
                fill_random();
                mode = 1'($urandom_range(1));
                tog  = 1'($urandom_range(1));
                rprob = $urandom_range(100, 40);
                push_model(s, mode);
                send_frame(gw[s]*gw[s], $urandom_range(100, 40), mode, tog);
            end
            rprob = 100;
            drain("rand_drain");
            chk(n_fd - fd0 == 4, "rand_frame_done_cnt", 32'(n_fd - fd0), 32'd4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
